lif_neuron_core: RTL and testbench

Leaky integrate-and-fire postsynaptic neuron that closes the loop around the STDP learning block. It consumes the 16 presynaptic spike lines and the learned 4-bit synaptic weights, and integrates them once per time step into a membrane potential. It emits the postsynaptic spike and a postsynaptic spike-history register that the STDP block samples. Weights are read serially through a select port, one synapse per cycle, in the same 0..15 order the STDP weight array is scanned.

---
 rtl/lif_neuron_core.sv | 181 ++++++++++++++++++
 tb/tb_lif_neuron_core.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/lif_neuron_core.sv
`default_nettype none
// ============================================================================
// Module   : lif_neuron_core
// Purpose  : Leaky integrate-and-fire postsynaptic neuron. On each accepted
//            time-step tick it latches the presynaptic spike levels. It then
//            scans the synaptic weights serially (one per cycle, index 0..N-1)
//            and sums the weights of the spiking synapses. In one final
//            update cycle it integrates, saturates, leaks and thresholds the
//            membrane potential.
// Ports    : clock, reset (async, active-high)
//            tick        - time-step strobe (ignored while busy -> overrun)
//            presyn      - presynaptic spike levels, latched on accepted tick
//            weight_sel  - synapse index being read (0 outside ACCUM)
//            weight_in   - weight of synapse weight_sel, same-cycle read
//            post_spike  - one-cycle fire pulse
//            post_sr     - postsynaptic history, bit 0 = newest step
//            vmem        - registered membrane potential
//            busy / done / overrun - status and one-cycle pulses
// Revision : 1.0 - initial release
// ============================================================================
module lif_neuron_core #(
  parameter int N_SYN     = 16,
  parameter int W_WIDTH   = 4,
  parameter int V_WIDTH   = 8,
  parameter int THRESHOLD = 40,
  parameter int LEAK      = 1,
  parameter int REFRACT   = 3,
  parameter int HIST      = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     tick,
  input  logic [N_SYN-1:0]         presyn,
  output logic [$clog2(N_SYN)-1:0] weight_sel,
  input  logic [W_WIDTH-1:0]       weight_in,
  output logic                     post_spike,
  output logic [HIST-1:0]          post_sr,
  output logic [V_WIDTH-1:0]       vmem,
  output logic                     busy,
  output logic                     done,
  output logic                     overrun
);

  localparam int SEL_W = $clog2(N_SYN);
  // Sum of N_SYN weights of W_WIDTH bits cannot exceed this width.
  localparam int ACC_W = W_WIDTH + SEL_W;
  // One extra bit above the wider operand so vmem + acc never wraps.
  localparam int SUM_W = ((V_WIDTH > ACC_W) ? V_WIDTH : ACC_W) + 1;
  localparam int REF_W = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_SYN - 1);
  localparam logic [SUM_W-1:0] V_MAX    = SUM_W'((1 << V_WIDTH) - 1);
  localparam logic [SUM_W-1:0] LEAK_S   = SUM_W'(LEAK);
  localparam logic [SUM_W-1:0] THR_S    = SUM_W'(THRESHOLD);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_UPDATE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [N_SYN-1:0]   spk_lat_q, spk_lat_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [V_WIDTH-1:0] vmem_q, vmem_d;
  logic [REF_W-1:0]   refr_cnt_q, refr_cnt_d;
  logic [HIST-1:0]    post_sr_q, post_sr_d;
  logic               post_spike_q, post_spike_d;
  logic               done_q, done_d;
  logic               overrun_q, overrun_d;

  logic [SUM_W-1:0]   sum_raw;
  logic [SUM_W-1:0]   sum_sat;
  logic [SUM_W-1:0]   leaked;
  logic               fire;

  // Membrane arithmetic: integrate, saturate to the vmem range, then leak
  // with a floor at zero, then compare against the threshold.
  always_comb begin
    sum_raw = SUM_W'(vmem_q) + SUM_W'(acc_q);
    sum_sat = (sum_raw > V_MAX) ? V_MAX : sum_raw;
    leaked  = (sum_sat >= LEAK_S) ? (sum_sat - LEAK_S) : '0;
    fire    = (leaked >= THR_S);
  end

  always_comb begin
    state_d      = state_q;
    spk_lat_d    = spk_lat_q;
    idx_d        = idx_q;
    acc_d        = acc_q;
    vmem_d       = vmem_q;
    refr_cnt_d   = refr_cnt_q;
    post_sr_d    = post_sr_q;
    post_spike_d = 1'b0;
    done_d       = 1'b0;
    // Any tick seen outside IDLE is dropped, including one in UPDATE.
    overrun_d    = tick && (state_q != S_IDLE);
    weight_sel   = '0;

    case (state_q)
      S_IDLE: begin
        if (tick) begin
          spk_lat_d = presyn;
          acc_d     = '0;
          idx_d     = '0;
          state_d   = S_ACCUM;
        end
      end

      S_ACCUM: begin
        weight_sel = idx_q;
        if (spk_lat_q[idx_q]) begin
          acc_d = acc_q + ACC_W'(weight_in);
        end
        idx_d = idx_q + SEL_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d = S_UPDATE;
        end
      end

      S_UPDATE: begin
        if (refr_cnt_q != '0) begin
          // Refractory: potential pinned at zero, input discarded.
          vmem_d     = '0;
          refr_cnt_d = refr_cnt_q - REF_W'(1);
          post_sr_d  = post_sr_q << 1;
        end else if (fire) begin
          vmem_d       = '0;
          refr_cnt_d   = REF_W'(REFRACT);
          post_spike_d = 1'b1;
          post_sr_d    = (post_sr_q << 1) | HIST'(1);
        end else begin
          vmem_d    = leaked[V_WIDTH-1:0];
          post_sr_d = post_sr_q << 1;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      spk_lat_q    <= '0;
      idx_q        <= '0;
      acc_q        <= '0;
      vmem_q       <= '0;
      refr_cnt_q   <= '0;
      post_sr_q    <= '0;
      post_spike_q <= 1'b0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      spk_lat_q    <= spk_lat_d;
      idx_q        <= idx_d;
      acc_q        <= acc_d;
      vmem_q       <= vmem_d;
      refr_cnt_q   <= refr_cnt_d;
      post_sr_q    <= post_sr_d;
      post_spike_q <= post_spike_d;
      done_q       <= done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign post_spike = post_spike_q;
  assign post_sr    = post_sr_q;
  assign vmem       = vmem_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign overrun    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_lif_neuron_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_lif_neuron_core
// Purpose  : Self-checking bench for lif_neuron_core. Two instances share the
//            stimulus: one with default parameters and one with THRESHOLD=255.
//            Expected values come from an arithmetic neuron model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lif_neuron_core;

  logic        clock;
  logic        reset;
  logic        tick;
  logic [15:0] presyn;
  logic [3:0]  w [16];

  logic [3:0]  wsel_a, wsel_s, win_a, win_s;
  logic        spike_a, spike_s, busy_a, busy_s, done_a, done_s, ovr_a, ovr_s;
  logic [2:0]  sr_a, sr_s;
  logic [7:0]  vmem_a, vmem_s;

  int checks = 0;
  int errors = 0;

  // Reference model state, index 0 = default instance, 1 = THRESHOLD 255.
  int m_vmem [2];
  int m_refr [2];
  int m_sr   [2];
  int m_fire [2];
  int thr    [2];

  assign win_a = w[wsel_a];
  assign win_s = w[wsel_s];

  lif_neuron_core u_dut (
    .clock(clock), .reset(reset), .tick(tick), .presyn(presyn),
    .weight_sel(wsel_a), .weight_in(win_a), .post_spike(spike_a),
    .post_sr(sr_a), .vmem(vmem_a), .busy(busy_a), .done(done_a),
    .overrun(ovr_a)
  );

  lif_neuron_core #(.THRESHOLD(255)) u_sat (
    .clock(clock), .reset(reset), .tick(tick), .presyn(presyn),
    .weight_sel(wsel_s), .weight_in(win_s), .post_spike(spike_s),
    .post_sr(sr_s), .vmem(vmem_s), .busy(busy_s), .done(done_s),
    .overrun(ovr_s)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_vmem[d] = 0; m_refr[d] = 0; m_sr[d] = 0; m_fire[d] = 0;
    end
  endtask

  // One time step of the neuron for a given total synaptic input.
  task automatic model_step(input int sum);
    int s;
    for (int d = 0; d < 2; d++) begin
      if (m_refr[d] > 0) begin
        m_refr[d] = m_refr[d] - 1;
        m_vmem[d] = 0;
        m_fire[d] = 0;
      end else begin
        s = m_vmem[d] + sum;
        if (s > 255) s = 255;
        s = (s >= 1) ? s - 1 : 0;
        if (s >= thr[d]) begin
          m_fire[d] = 1; m_vmem[d] = 0; m_refr[d] = 3;
        end else begin
          m_fire[d] = 0; m_vmem[d] = s;
        end
      end
      m_sr[d] = ((m_sr[d] << 1) | m_fire[d]) & 7;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".weight_sel"}, 32'(wsel_a), 0);
    check({tag, ".post_spike"}, 32'(spike_a), 0);
    check({tag, ".post_sr"},    32'(sr_a), 0);
    check({tag, ".vmem"},       32'(vmem_a), 0);
    check({tag, ".busy"},       32'(busy_a), 0);
    check({tag, ".done"},       32'(done_a), 0);
    check({tag, ".overrun"},    32'(ovr_a), 0);
    check({tag, ".vmem_sat"},   32'(vmem_s), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick  = 1'b0;
    repeat (2) @(negedge clock);
    check_all_zero("reset");
    reset = 1'b0;
    model_reset();
    @(negedge clock);
  endtask

  // Issue one accepted tick with spike pattern p. extra_k != 0 raises a second
  // tick at cycle extra_k (must be dropped). rst_k != 0 resets mid-step.
  // gap = idle cycles after the update before returning.
  task automatic run_step(input logic [15:0] p, input int extra_k, input int rst_k, input int gap);
    int sum;
    sum = 0;
    for (int i = 0; i < 16; i++) if (p[i]) sum += int'(w[i]);
    presyn = p;
    tick   = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clock);
      tick   = (k == extra_k);
      presyn = 16'($urandom);
      if (k <= 16) check("weight_sel", 32'(wsel_a), 32'(k - 1));
      if (k <= 17) check("busy", 32'(busy_a), 1);
      check("done", 32'(done_a), 32'(k == 18));
      check("overrun", 32'(ovr_a), 32'((extra_k != 0) && (k == extra_k + 1)));
      if (k == rst_k) begin
        tick  = 1'b0;
        reset = 1'b1;
        #1;
        check_all_zero("reset_mid");
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        return;
      end
      if (k == 18) begin
        model_step(sum);
        check("vmem",       32'(vmem_a),  32'(m_vmem[0]));
        check("post_spike", 32'(spike_a), 32'(m_fire[0]));
        check("post_sr",    32'(sr_a),    32'(m_sr[0]));
        check("busy_end",   32'(busy_a),  0);
        check("vmem_sat",   32'(vmem_s),  32'(m_vmem[1]));
        check("spike_sat",  32'(spike_s), 32'(m_fire[1]));
        check("sr_sat",     32'(sr_s),    32'(m_sr[1]));
        check("done_sat",   32'(done_s),  1);
      end
    end
    for (int g = 0; g < gap; g++) begin
      @(negedge clock);
      presyn = 16'($urandom);
      check("idle_busy",  32'(busy_a),  0);
      check("idle_done",  32'(done_a),  0);
      check("idle_spike", 32'(spike_a), 0);
    end
  endtask

  initial begin
    thr[0] = 40;
    thr[1] = 255;
    reset  = 1'b1;
    tick   = 1'b0;
    presyn = '0;
    for (int i = 0; i < 16; i++) w[i] = 4'd0;
    model_reset();
    do_reset();

    // Single synapse integration, ticks every 20 cycles.
    for (int i = 0; i < 16; i++) w[i] = 4'($urandom_range(0, 15));
    w[5] = 4'd10;
    repeat (5) run_step(16'h0020, 0, 0, 2);

    // Refractory window with full drive, back-to-back ticks.
    for (int i = 0; i < 16; i++) w[i] = 4'd15;
    repeat (4) run_step(16'hFFFF, 0, 0, 0);

    // Saturation.
    do_reset();
    repeat (3) run_step(16'hFFFF, 0, 0, 1);

    // Leak floor: reach vmem 2, then no input.
    do_reset();
    w[0] = 4'd3;
    run_step(16'h0001, 0, 0, 1);
    repeat (3) run_step(16'h0000, 0, 0, 1);

    // Overrun: tick during ACCUM, and tick during the UPDATE cycle.
    for (int i = 0; i < 16; i++) w[i] = 4'($urandom_range(0, 15));
    run_step(16'($urandom), 5, 0, 1);
    run_step(16'($urandom), 17, 0, 0);

    // Reset while weight_sel = 7, then a normal update.
    run_step(16'hFFFF, 0, 8, 0);
    run_step(16'($urandom), 0, 0, 1);

    // Randomized steps.
    repeat (30) begin
      for (int i = 0; i < 16; i++) w[i] = 4'($urandom_range(0, 15));
      run_step(16'($urandom),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 17)) : 0,
               0, int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
